// File: rtl/mem_master_pkg.sv
// mem_master shared types: FSM state, default widths, response FIFO entry.
package mem_master_pkg;

    localparam int ADDR_W_DEF    = 10;
    localparam int DATA_W_DEF    = 32;
    localparam int LEN_W_DEF     = 3;
    localparam int RSP_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  last;
        logic                  err;
    } rsp_t;

endpackage

// File: rtl/mem_master_rsp_fifo.sv
// Response FIFO for mem_master: synchronous, sync active-high reset.
module mem_master_rsp_fifo
    import mem_master_pkg::*;
#(
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  rsp_t din,
    input  logic pop,
    output rsp_t dout,
    output logic empty
);

    localparam int AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    rsp_t          buf_q [RSP_DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(RSP_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) buf_q[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= nxt(wp);
            if (pop)  rp <= nxt(rp);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: ;
            endcase
        end
    end

    assign dout  = buf_q[rp];
    assign empty = (cnt == '0);

endmodule

// File: rtl/mem_master.sv
// Memory-port initiator: single writes, 1-8 word credit-limited read bursts.
// Option: MEM_MASTER_WRAP_ERR_EN rejects reads that cross the top address.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              wr_ack,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int LW = LEN_W + 1;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LW-1:0]     left_q;
    logic              err_q;
    logic [CW-1:0]     credit;
    logic              mem_last;
    logic              tok_err;
    logic              cap_v;
    logic              cap_last;
    logic              cap_err;

    logic              accept;
    logic              pop;
    logic              empty;
    logic              wrap;
    logic              pend_v;
    logic              pend_err;
    logic [ADDR_W-1:0] pend_addr;
    logic [LW-1:0]     pend_left;
    logic              room;
    logic              iss;
    logic              last_beat;
    rsp_t              head;
    rsp_t              din;

    assign req_ready = !reset && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

`ifdef MEM_MASTER_WRAP_ERR_EN
    logic [ADDR_W:0] end_addr;
    assign end_addr = {1'b0, req_addr} + (ADDR_W + 1)'(req_len);
    assign wrap     = end_addr[ADDR_W];
`else
    assign wrap = 1'b0;
`endif

    // The beat eligible to issue at the coming edge: a freshly accepted
    // read, or the remainder of the burst being walked in READ.
    always_comb begin
        pend_v    = 1'b0;
        pend_addr = addr_q;
        pend_left = left_q;
        pend_err  = err_q;
        if (state == READ) begin
            pend_v = 1'b1;
        end else if (accept && !req_write) begin
            pend_v    = 1'b1;
            pend_addr = req_addr;
            pend_left = LW'(req_len) + LW'(1);
            pend_err  = wrap;
        end
        room      = (credit - CW'(pop)) < CW'(RSP_DEPTH);
        iss       = pend_v && room;
        last_beat = (pend_left == LW'(1)) || pend_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            left_q     <= '0;
            err_q      <= 1'b0;
            credit     <= '0;
            mem_enable <= 1'b0;
            mem_rw     <= 1'b0;
            mem_add    <= '0;
            mem_wdata  <= '0;
            wr_ack     <= 1'b0;
            mem_last   <= 1'b0;
            tok_err    <= 1'b0;
            cap_v      <= 1'b0;
            cap_last   <= 1'b0;
            cap_err    <= 1'b0;
        end else begin
            mem_enable <= 1'b0;
            wr_ack     <= 1'b0;
            tok_err    <= 1'b0;
            cap_v      <= (mem_enable && !mem_rw) || tok_err;
            cap_last   <= mem_last;
            cap_err    <= tok_err;
            credit     <= credit + CW'(iss) - CW'(pop);
            case (state)
                IDLE: begin
                    if (accept && req_write) begin
                        state      <= WRITE;
                        mem_enable <= 1'b1;
                        mem_rw     <= 1'b1;
                        mem_add    <= req_addr;
                        mem_wdata  <= req_wdata;
                        wr_ack     <= 1'b1;
                    end
                end
                WRITE:   state <= IDLE;
                default: ;
            endcase
            if (pend_v) begin
                err_q <= pend_err;
                if (iss) begin
                    addr_q   <= pend_addr + ADDR_W'(1);
                    left_q   <= pend_left - LW'(1);
                    mem_last <= last_beat;
                    state    <= last_beat ? IDLE : READ;
                    // A rejected burst takes a credit but never strobes.
                    if (pend_err) begin
                        tok_err <= 1'b1;
                    end else begin
                        mem_enable <= 1'b1;
                        mem_rw     <= 1'b0;
                        mem_add    <= pend_addr;
                    end
                end else begin
                    addr_q <= pend_addr;
                    left_q <= pend_left;
                    state  <= READ;
                end
            end
        end
    end

    assign din = '{data: cap_err ? '0 : mem_rdata,
                   last: cap_last,
                   err:  cap_err};

    mem_master_rsp_fifo #(
        .RSP_DEPTH(RSP_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (cap_v),
        .din  (din),
        .pop  (pop),
        .dout (head),
        .empty(empty)
    );

    assign rsp_valid = !empty;
    assign rsp_data  = rsp_valid ? head.data : '0;
    assign rsp_last  = rsp_valid && head.last;
    assign rsp_err   = rsp_valid && head.err;
    assign busy      = !reset && ((state != IDLE) || (credit != '0));

endmodule

// File: doc/mem_master.md
# mem_master

Bus-side initiator for the single-port synchronous word memory (10-bit word address, 32-bit data, enable/rw strobe, one-cycle registered read data). It accepts single-word write and 1–8-word read-burst requests from a core over a valid/ready channel, and drives the memory port with registered strobes. Read data is returned in order on a valid/ready response stream, backed by a credit-limited response FIFO.

## Interface
- ADDR_W, 10, word address width
- DATA_W, 32, data width
- LEN_W, 3, burst length field; burst words = req_len + 1
- RSP_DEPTH, 4, response FIFO entries and read-credit limit; minimum 3
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when both high at clk edge
- req_write  in  1  1 = write one word, 0 = read burst
- req_addr  in  ADDR_W  start word address
- req_wdata  in  DATA_W  write data; ignored for reads
- req_len  in  LEN_W  read words minus 1; ignored for writes
- wr_ack  out  1  one-cycle pulse, concurrent with the memory write strobe
- rsp_valid  out  1  response beat available
- rsp_ready  in  1  response beat consumed when both high
- rsp_data  out  DATA_W  read data
- rsp_last  out  1  final beat of a burst
- rsp_err  out  1  burst rejected; tied 0 unless the macro is defined
- mem_enable  out  1  memory access strobe, registered
- mem_rw  out  1  0 = read, 1 = write, registered
- mem_add  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data; valid the cycle after a read strobe
- busy  out  1  high outside IDLE or while credit is nonzero

## Operation
- FSM states: IDLE, WRITE, READ.
- IDLE: req_ready=1. On acceptance, latch the request and move to WRITE or READ.
- WRITE: one cycle. mem_enable=1, mem_rw=1, mem_add and mem_wdata come from the latch, wr_ack=1. Then return to IDLE.
- READ: issue one beat per cycle when credit < RSP_DEPTH (mem_enable=1, mem_rw=0, mem_add = current address). After each issue, address increments and the remaining count decrements. Address arithmetic is modulo 2^ADDR_W, so 1023+1 wraps to 0. After the last beat issues, go to IDLE. A new request may be accepted while earlier beats are still in flight; memory ordering preserves correctness.
- Credit counter (0..RSP_DEPTH): +1 on issue, −1 on pop. Both in one cycle leaves it unchanged.
- Capture: mem_rdata is pushed to the FIFO in the cycle after its strobe, tagged with its last flag. The credit limit guarantees the FIFO never overflows.
- rsp_valid = FIFO not empty. The FIFO head drives rsp_data and rsp_last.
- In cycles where mem_enable=0, mem_rw, mem_add and mem_wdata hold their previous values.
- Reset: state IDLE, FIFO empty, credit 0. All outputs are 0 (req_ready=0) during reset. req_ready=1 in the first cycle after reset deasserts. Reset mid-burst discards in-flight beats.

## Timing
- Request accepted at the end of cycle 0.
- Write: strobe and wr_ack in cycle 1; req_ready=1 again in cycle 2.
- Read: beat k strobes in cycle 1+k when unthrottled. mem_rdata is valid in cycle 2+k, and rsp_valid for beat k appears in cycle 3+k.
- With rsp_ready held high and RSP_DEPTH≥3, throughput is 1 beat/cycle.
- rsp_ready low: issue stalls once credit = RSP_DEPTH, and resumes the cycle after a pop.

## Configuration
- Macro: MEM_MASTER_WRAP_ERR_EN.
- Defined: a read with req_addr + req_len > 2^ADDR_W−1 issues no memory access. It produces one response beat: rsp_err=1, rsp_last=1, rsp_data=0 (costs 1 credit).
- Undefined: such bursts wrap to address 0, and rsp_err is constant 0.

## Structure
- Package mem_master_pkg holds the FSM state enum, ADDR_W/DATA_W/LEN_W defaults, and the response entry struct {data, last, err}.
- Sub-module mem_master_rsp_fifo: synchronous FIFO with parameter depth RSP_DEPTH, push/pop, and the same synchronous reset.

## Test plan
- Fresh reset; write 0xDEADBEEF to addr 5, then read len 0 at addr 5 → wr_ack in cycle 1; rsp_data=0xDEADBEEF, rsp_last=1, rsp_valid first in cycle 3 after read acceptance.
- After reset (memory program image loaded), read len 3 at addr 8 with rsp_ready=1 → 4 consecutive beats 0x59002000, 0x59804000, 0x5A006000, 0x5A808000; rsp_last only on the 4th.
- Read len 7 at addr 0, rsp_ready=0 for 10 cycles → exactly RSP_DEPTH strobes, then a stall. After release, beats are 0x68100000, 0xC00, 0x80000800 ×3, 0x800, 0x80, 0x0 with none lost or duplicated.
- Read len 1 at addr 1023 → mem_add sequence 1023, 0; data 0x0 then 0x68100000. With MEM_MASTER_WRAP_ERR_EN: no strobe, single beat rsp_err=1, rsp_last=1.
- Assert reset during beat 3 of an 8-beat read → next cycle mem_enable=0 and rsp_valid=0; after release req_ready=1 and busy=0.
